// File: rtl/mips_mc_pkg.sv
// ============================================================================
// mips_mc_pkg : state encodings, opcodes and control constants shared by the
// multi-cycle MIPS controller. Revision 1.0
// ============================================================================
`default_nettype none

package mips_mc_pkg;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWB  = 4'd5;
   localparam logic [3:0] S_MEMWR  = 4'd6;
   localparam logic [3:0] S_EXEC   = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_ADDIEX = 4'd10;
   localparam logic [3:0] S_ADDIWB = 4'd11;
   localparam logic [3:0] S_JUMP   = 4'd12;

   // Same encodings as the single-cycle decoder
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
             (op == OP_BNE) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_outdec.sv
// ============================================================================
// mc_ctrl_outdec : combinational state -> control word decode (Moore outputs).
// Optional macro MC_MEM_WAIT_EN gates fetch/store strobes with memory ready.
// Revision 1.0
// ============================================================================
`default_nettype none

module mc_ctrl_outdec
   import mips_mc_pkg::*;
(
   input  logic [3:0] i_state,
   input  logic [5:0] i_opcode,
   input  logic       i_mem_ready,
   output ctrl_t      o_ctrl
);

   logic w_rdy;

`ifdef MC_MEM_WAIT_EN
   assign w_rdy = i_mem_ready;
`else
   logic w_unused_mem_ready;
   assign w_unused_mem_ready = i_mem_ready;
   assign w_rdy = 1'b1;
`endif

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            // PC/IR capture only once the instruction word is actually there
            o_ctrl.mem_read  = 1'b1;
            o_ctrl.alu_src_b = SRCB_FOUR;
            o_ctrl.pc_write  = w_rdy;
            o_ctrl.ir_write  = w_rdy;
         end
         S_DECODE: begin
            o_ctrl.alu_src_b  = SRCB_IMMSH;
            o_ctrl.instr_done = ~is_legal_op(i_opcode);
         end
         S_MEMADR: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            o_ctrl.mem_read = 1'b1;
            o_ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            o_ctrl.mem_to_reg = 1'b1;
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         S_MEMWR: begin
            o_ctrl.mem_write  = 1'b1;
            o_ctrl.iord       = 1'b1;
            o_ctrl.instr_done = w_rdy;
         end
         S_EXEC: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            o_ctrl.reg_dst    = 1'b1;
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            o_ctrl.alu_src_a     = 1'b1;
            o_ctrl.alu_op        = ALUOP_SUB;
            o_ctrl.pc_source     = PCSRC_ALUOUT;
            o_ctrl.pc_write_cond = 1'b1;
            o_ctrl.branch_ne     = (i_opcode == OP_BNE);
            o_ctrl.instr_done    = 1'b1;
         end
         S_ADDIEX: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
         end
         S_ADDIWB: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         S_JUMP: begin
            o_ctrl.pc_source  = PCSRC_JUMP;
            o_ctrl.pc_write   = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// mips_multicycle_ctrl : multi-cycle MIPS control FSM (state register,
// next-state logic, sticky illegal-opcode flag). Optional macro MC_MEM_WAIT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl
   import mips_mc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       BranchNe,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   logic [3:0] r_state;
   logic [3:0] w_next;
   logic       r_illegal_op;
   logic       w_rdy;
   ctrl_t      w_ctrl;

`ifdef MC_MEM_WAIT_EN
   assign w_rdy = mem_ready;
`else
   assign w_rdy = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = S_FETCH;
         S_FETCH:  w_next = w_rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_R:           w_next = S_EXEC;
               OP_LW, OP_SW:   w_next = S_MEMADR;
               OP_BEQ, OP_BNE: w_next = S_BRANCH;
               OP_ADDI:        w_next = S_ADDIEX;
               OP_J:           w_next = S_JUMP;
               default:        w_next = S_FETCH;
            endcase
         end
         S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_next = w_rdy ? S_MEMWB : S_MEMRD;
         S_MEMWR:  w_next = w_rdy ? S_FETCH : S_MEMWR;
         S_EXEC:   w_next = S_ALUWB;
         S_ADDIEX: w_next = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_next = S_FETCH;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_illegal_op <= 1'b0;
      else if ((r_state == S_DECODE) && !is_legal_op(opcode))
         r_illegal_op <= 1'b1;
   end

   mc_ctrl_outdec u_outdec (
      .i_state     (r_state),
      .i_opcode    (opcode),
      .i_mem_ready (mem_ready),
      .o_ctrl      (w_ctrl)
   );

   assign PCWrite     = w_ctrl.pc_write;
   assign PCWriteCond = w_ctrl.pc_write_cond;
   assign BranchNe    = w_ctrl.branch_ne;
   assign IorD        = w_ctrl.iord;
   assign MemRead     = w_ctrl.mem_read;
   assign MemWrite    = w_ctrl.mem_write;
   assign IRWrite     = w_ctrl.ir_write;
   assign RegDst      = w_ctrl.reg_dst;
   assign MemtoReg    = w_ctrl.mem_to_reg;
   assign RegWrite    = w_ctrl.reg_write;
   assign ALUSrcA     = w_ctrl.alu_src_a;
   assign ALUSrcB     = w_ctrl.alu_src_b;
   assign ALUOp       = w_ctrl.alu_op;
   assign PCSource    = w_ctrl.pc_source;
   assign instr_done  = w_ctrl.instr_done;
   assign illegal_op  = r_illegal_op;
   assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
// tb_mips_multicycle_ctrl : table-driven bench for the multi-cycle controller,
// with hand sequences for reset abort and (with MC_MEM_WAIT_EN) memory waits.
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mips_multicycle_ctrl;
   import mips_mc_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b1;
   logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
   logic       RegDst, MemtoReg, RegWrite, ALUSrcA, instr_done, illegal_op;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   mips_multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
   );

   logic [17:0] w_ctl;
   assign w_ctl = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                   RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done};

   function automatic logic [17:0] mk(input logic pcw, pcwc, bne, iord, mr, mw, irw,
                                      rd, m2r, rw, asa, input logic [1:0] asb, aop, pcs,
                                      input logic done);
      return {pcw, pcwc, bne, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, done};
   endfunction

   logic [17:0] C_FETCH, C_FETCH_WAIT, C_DEC, C_DEC_ILL, C_MEMADR, C_MEMRD, C_MEMWB;
   logic [17:0] C_MEMWR, C_MEMWR_WAIT, C_EXEC, C_ALUWB, C_BEQ, C_BNE, C_ADDIEX, C_ADDIWB, C_JUMP;

   typedef struct {
      logic [5:0]  op;
      logic [3:0]  st;
      logic [17:0] ctl;
      logic        ill;
   } vec_t;

   vec_t tbl [0:39];
   int   n_tbl = 0;

   task automatic add(input logic [5:0] op, input logic [3:0] st, input logic [17:0] ctl,
                      input logic ill);
      tbl[n_tbl].op  = op;
      tbl[n_tbl].st  = st;
      tbl[n_tbl].ctl = ctl;
      tbl[n_tbl].ill = ill;
      n_tbl++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One clock: inputs for the newly entered state are applied just after the edge
   task automatic step(input string nm, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [17:0] ctl, input logic ill);
      @(posedge clk);
      #1;
      opcode    = op;
      mem_ready = rdy;
      @(negedge clk);
      if (instr_done) done_cnt++;
      chk({nm, "_state"}, {28'd0, state}, {28'd0, st});
      chk({nm, "_ctl"}, {14'd0, w_ctl}, {14'd0, ctl});
      chk({nm, "_ill"}, {31'd0, illegal_op}, {31'd0, ill});
   endtask

   initial begin
      C_FETCH      = mk(1,0,0,0,1,0,1,0,0,0,0,SRCB_FOUR,ALUOP_ADD,PCSRC_ALU,0);
      C_FETCH_WAIT = mk(0,0,0,0,1,0,0,0,0,0,0,SRCB_FOUR,ALUOP_ADD,PCSRC_ALU,0);
      C_DEC        = mk(0,0,0,0,0,0,0,0,0,0,0,SRCB_IMMSH,ALUOP_ADD,PCSRC_ALU,0);
      C_DEC_ILL    = mk(0,0,0,0,0,0,0,0,0,0,0,SRCB_IMMSH,ALUOP_ADD,PCSRC_ALU,1);
      C_MEMADR     = mk(0,0,0,0,0,0,0,0,0,0,1,SRCB_IMM,ALUOP_ADD,PCSRC_ALU,0);
      C_MEMRD      = mk(0,0,0,1,1,0,0,0,0,0,0,SRCB_B,ALUOP_ADD,PCSRC_ALU,0);
      C_MEMWB      = mk(0,0,0,0,0,0,0,0,1,1,0,SRCB_B,ALUOP_ADD,PCSRC_ALU,1);
      C_MEMWR      = mk(0,0,0,1,0,1,0,0,0,0,0,SRCB_B,ALUOP_ADD,PCSRC_ALU,1);
      C_MEMWR_WAIT = mk(0,0,0,1,0,1,0,0,0,0,0,SRCB_B,ALUOP_ADD,PCSRC_ALU,0);
      C_EXEC       = mk(0,0,0,0,0,0,0,0,0,0,1,SRCB_B,ALUOP_FUNCT,PCSRC_ALU,0);
      C_ALUWB      = mk(0,0,0,0,0,0,0,1,0,1,0,SRCB_B,ALUOP_ADD,PCSRC_ALU,1);
      C_BEQ        = mk(0,1,0,0,0,0,0,0,0,0,1,SRCB_B,ALUOP_SUB,PCSRC_ALUOUT,1);
      C_BNE        = mk(0,1,1,0,0,0,0,0,0,0,1,SRCB_B,ALUOP_SUB,PCSRC_ALUOUT,1);
      C_ADDIEX     = mk(0,0,0,0,0,0,0,0,0,0,1,SRCB_IMM,ALUOP_ADD,PCSRC_ALU,0);
      C_ADDIWB     = mk(0,0,0,0,0,0,0,0,0,1,0,SRCB_B,ALUOP_ADD,PCSRC_ALU,1);
      C_JUMP       = mk(1,0,0,0,0,0,0,0,0,0,0,SRCB_B,ALUOP_ADD,PCSRC_JUMP,1);

      // lw: 5 cycles
      add(6'b100011, S_FETCH, C_FETCH, 0);  add(6'b100011, S_DECODE, C_DEC, 0);
      add(6'b100011, S_MEMADR, C_MEMADR, 0); add(6'b100011, S_MEMRD, C_MEMRD, 0);
      add(6'b100011, S_MEMWB, C_MEMWB, 0);
      // beq, bne: 3 cycles each
      add(6'b000100, S_FETCH, C_FETCH, 0);  add(6'b000100, S_DECODE, C_DEC, 0);
      add(6'b000100, S_BRANCH, C_BEQ, 0);
      add(6'b000101, S_FETCH, C_FETCH, 0);  add(6'b000101, S_DECODE, C_DEC, 0);
      add(6'b000101, S_BRANCH, C_BNE, 0);
      // illegal then R-type: flag rises on leaving DECODE and stays
      add(6'b111111, S_FETCH, C_FETCH, 0);  add(6'b111111, S_DECODE, C_DEC_ILL, 0);
      add(6'b000000, S_FETCH, C_FETCH, 1);  add(6'b000000, S_DECODE, C_DEC, 1);
      add(6'b000000, S_EXEC, C_EXEC, 1);    add(6'b000000, S_ALUWB, C_ALUWB, 1);
      // back-to-back illegal opcodes
      add(6'b111111, S_FETCH, C_FETCH, 1);  add(6'b111111, S_DECODE, C_DEC_ILL, 1);
      add(6'b010101, S_FETCH, C_FETCH, 1);  add(6'b010101, S_DECODE, C_DEC_ILL, 1);
      // addi, j
      add(6'b001000, S_FETCH, C_FETCH, 1);  add(6'b001000, S_DECODE, C_DEC, 1);
      add(6'b001000, S_ADDIEX, C_ADDIEX, 1); add(6'b001000, S_ADDIWB, C_ADDIWB, 1);
      add(6'b000010, S_FETCH, C_FETCH, 1);  add(6'b000010, S_DECODE, C_DEC, 1);
      add(6'b000010, S_JUMP, C_JUMP, 1);
      // sw, stopped in MEMWR for the reset-abort check
      add(6'b101011, S_FETCH, C_FETCH, 1);  add(6'b101011, S_DECODE, C_DEC, 1);
      add(6'b101011, S_MEMADR, C_MEMADR, 1); add(6'b101011, S_MEMWR, C_MEMWR, 1);

      repeat (3) @(negedge clk);
      chk("reset_state", {28'd0, state}, {28'd0, S_IDLE});
      chk("reset_ctl", {14'd0, w_ctl}, 32'd0);
      chk("reset_ill", {31'd0, illegal_op}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < n_tbl; i++)
         step($sformatf("vec%0d", i), tbl[i].op, 1'b1, tbl[i].st, tbl[i].ctl, tbl[i].ill);
      chk("done_pulses", done_cnt, 10);

      // asynchronous reset in the middle of a store
      #2 rst_n = 1'b0;
      #1;
      chk("abort_memwrite", {31'd0, MemWrite}, 32'd0);
      chk("abort_state", {28'd0, state}, {28'd0, S_IDLE});
      chk("abort_ill", {31'd0, illegal_op}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef MC_MEM_WAIT_EN
      for (int i = 0; i < 3; i++)
         step($sformatf("wfetch%0d", i), 6'b101011, 1'b0, S_FETCH, C_FETCH_WAIT, 0);
      step("wfetch3", 6'b101011, 1'b1, S_FETCH, C_FETCH, 0);
      step("wdec", 6'b101011, 1'b1, S_DECODE, C_DEC, 0);
      step("wadr", 6'b101011, 1'b0, S_MEMADR, C_MEMADR, 0);
      for (int i = 0; i < 2; i++)
         step($sformatf("wmemwr%0d", i), 6'b101011, 1'b0, S_MEMWR, C_MEMWR_WAIT, 0);
      step("wmemwr2", 6'b101011, 1'b1, S_MEMWR, C_MEMWR, 0);
      step("wnext", 6'b000000, 1'b1, S_FETCH, C_FETCH, 0);
`else
      step("nfetch", 6'b101011, 1'b0, S_FETCH, C_FETCH, 0);
      step("ndec", 6'b101011, 1'b0, S_DECODE, C_DEC, 0);
      step("nadr", 6'b101011, 1'b0, S_MEMADR, C_MEMADR, 0);
      step("nmemwr", 6'b101011, 1'b0, S_MEMWR, C_MEMWR, 0);
      step("nnext", 6'b000000, 1'b0, S_FETCH, C_FETCH, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
